// File: rtl/demux_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : demux_frame_ctrl
// Brief   : Serial command-frame decoder driving the sel/a/en inputs of the
//           1-to-8 demultiplexer, with framing-error flag and good-frame count.
// Revision: 1.0 - initial release
// ============================================================================
module demux_frame_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             bit_tick,
    output logic [2:0]       sel,
    output logic             a,
    output logic             en,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_DRIVE = 3'd4;

    // Hold counter preloads with HOLD_CYCLES-1 so en spans exactly HOLD_CYCLES clocks
    localparam logic [7:0] c_HOLD_INIT = 8'(HOLD_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_bitcnt;
    logic [2:0] r_addr;
    logic       r_data;
    logic [7:0] r_hold;

    logic       w_start;
    logic       w_shift;
    logic       w_latch;
    logic       w_load;
    logic       w_bad;
    logic       w_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (bit_tick && !ser_in)              w_next_state = c_ADDR;
            c_ADDR:  if (bit_tick && (r_bitcnt == 2'd2))   w_next_state = c_DATA;
            c_DATA:  if (bit_tick)                         w_next_state = c_STOP;
            c_STOP:  if (bit_tick)                         w_next_state = ser_in ? c_DRIVE : c_IDLE;
            c_DRIVE: if (r_hold == 8'd0)                   w_next_state = c_IDLE;
            default:                                       w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != c_IDLE);
        w_start = (r_state == c_IDLE) && bit_tick && !ser_in;
        w_shift = (r_state == c_ADDR) && bit_tick;
        w_latch = (r_state == c_DATA) && bit_tick;
        w_load  = (r_state == c_STOP) && bit_tick && ser_in;
        w_bad   = (r_state == c_STOP) && bit_tick && !ser_in;
        w_drive = (r_state == c_DRIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt  <= 2'd0;
            r_addr    <= 3'd0;
            r_data    <= 1'b0;
            r_hold    <= 8'd0;
            sel       <= 3'd0;
            a         <= 1'b0;
            en        <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= w_bad;
            if (w_start) begin
                r_bitcnt <= 2'd0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + 2'd1;
            end
            if (w_shift) begin
                r_addr <= {r_addr[1:0], ser_in};
            end
            if (w_latch) begin
                r_data <= ser_in;
            end
            if (w_load) begin
                sel       <= r_addr;
                a         <= r_data;
                en        <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
                r_hold    <= c_HOLD_INIT;
            end else if (w_drive) begin
                // sel/a deliberately keep their values after en drops
                if (r_hold == 8'd0) begin
                    en <= 1'b0;
                end else begin
                    r_hold <= r_hold - 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_frame_ctrl
// Brief   : Scoreboard bench for demux_frame_ctrl; a default instance and a
//           HOLD_CYCLES=1 / CNT_W=2 instance share the same serial stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_demux_frame_ctrl;

    typedef struct {
        bit         err;
        logic [2:0] sel;
        logic       a;
        logic [7:0] cnt;
    } exp_t;

    logic       r_clk;
    logic       r_rst_n;
    logic       r_ser_in;
    logic       r_bit_tick;

    logic [2:0] w_sel0, w_sel1;
    logic       w_a0, w_a1, w_en0, w_en1, w_busy0, w_busy1, w_ferr0, w_ferr1;
    logic [7:0] w_cnt0;
    logic [1:0] w_cnt1;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks;
    int         n_errors;
    logic [7:0] m_cnt0;
    logic [1:0] m_cnt1;
    logic [2:0] m_sel;
    logic       m_a;
    bit   [1:0] en_prev;
    int         width[2];

    demux_frame_ctrl dut0 (
        .clk(r_clk), .rst_n(r_rst_n), .ser_in(r_ser_in), .bit_tick(r_bit_tick),
        .sel(w_sel0), .a(w_a0), .en(w_en0), .busy(w_busy0),
        .frame_err(w_ferr0), .frame_cnt(w_cnt0)
    );

    demux_frame_ctrl #(.HOLD_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(r_clk), .rst_n(r_rst_n), .ser_in(r_ser_in), .bit_tick(r_bit_tick),
        .sel(w_sel1), .a(w_a1), .en(w_en1), .busy(w_busy1),
        .frame_err(w_ferr1), .frame_cnt(w_cnt1)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic on_event(input int k, input bit err, input logic [2:0] s,
                            input logic av, input logic [7:0] c, input logic e);
        exp_t x;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event dut%0d: got err=%0d, expected no event", k, err);
        end else begin
            x = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("event_kind%0d", k), 32'(err), 32'(x.err));
            chk($sformatf("sel%0d", k), 32'(s), 32'(x.sel));
            chk($sformatf("a%0d", k), 32'(av), 32'(x.a));
            chk($sformatf("frame_cnt%0d", k), 32'(c), 32'(x.cnt));
            if (err) chk($sformatf("en_on_err%0d", k), 32'(e), 32'd0);
        end
    endtask

    // Monitor: pops expectations whenever a DUT raises en or frame_err
    always @(negedge r_clk) begin
        for (int k = 0; k < 2; k++) begin
            logic       e, f, av;
            logic [2:0] s;
            logic [7:0] c;
            e  = (k == 0) ? w_en0   : w_en1;
            f  = (k == 0) ? w_ferr0 : w_ferr1;
            s  = (k == 0) ? w_sel0  : w_sel1;
            av = (k == 0) ? w_a0    : w_a1;
            c  = (k == 0) ? w_cnt0  : {6'd0, w_cnt1};
            if (!r_rst_n) begin
                en_prev[k] = 1'b0;
                width[k]   = 0;
            end else begin
                if (e && !en_prev[k]) on_event(k, 1'b0, s, av, c, e);
                if (f)                on_event(k, 1'b1, s, av, c, e);
                if (e) begin
                    width[k]++;
                end else if (en_prev[k]) begin
                    chk($sformatf("en_width%0d", k), 32'(width[k]), (k == 0) ? 32'd4 : 32'd1);
                    width[k] = 0;
                end
                en_prev[k] = e;
            end
        end
    end

    task automatic tick(input logic b);
        @(posedge r_clk); #1;
        r_ser_in   = b;
        r_bit_tick = 1'b1;
        @(posedge r_clk); #1;
        r_bit_tick = 1'b0;
        r_ser_in   = 1'b1;
    endtask

    task automatic expect_frame(input logic [2:0] addr, input logic d, input logic stop);
        exp_t x;
        if (stop) begin
            m_cnt0 = m_cnt0 + 8'd1;
            m_cnt1 = m_cnt1 + 2'd1;
            m_sel  = addr;
            m_a    = d;
        end
        x.err = !stop; x.sel = m_sel; x.a = m_a; x.cnt = m_cnt0;
        q0.push_back(x);
        x.cnt = {6'd0, m_cnt1};
        q1.push_back(x);
    endtask

    task automatic send_frame(input logic [2:0] addr, input logic d, input logic stop, input int gap);
        expect_frame(addr, d, stop);
        tick(1'b0); tick(addr[2]); tick(addr[1]); tick(addr[0]); tick(d); tick(stop);
        repeat (gap) @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        #1;
        chk("rst_sel0", 32'(w_sel0), 32'd0);
        chk("rst_a0", 32'(w_a0), 32'd0);
        chk("rst_en0", 32'(w_en0), 32'd0);
        chk("rst_busy0", 32'(w_busy0), 32'd0);
        chk("rst_ferr0", 32'(w_ferr0), 32'd0);
        chk("rst_cnt0", 32'(w_cnt0), 32'd0);
        chk("rst_busy1", 32'(w_busy1), 32'd0);
        chk("rst_cnt1", 32'(w_cnt1), 32'd0);
        m_cnt0 = 8'd0; m_cnt1 = 2'd0; m_sel = 3'd0; m_a = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        m_cnt0 = 8'd0; m_cnt1 = 2'd0; m_sel = 3'd0; m_a = 1'b0;
        r_rst_n = 1'b0; r_ser_in = 1'b1; r_bit_tick = 1'b0;
        repeat (3) @(posedge r_clk);
        #1;
        chk("init_sel0", 32'(w_sel0), 32'd0);
        chk("init_en0", 32'(w_en0), 32'd0);
        chk("init_busy0", 32'(w_busy0), 32'd0);
        chk("init_cnt0", 32'(w_cnt0), 32'd0);
        r_rst_n = 1'b1;

        // Good frame: addr 101, D=1
        send_frame(3'b101, 1'b1, 1'b1, 8);
        chk("hold_sel0", 32'(w_sel0), 32'd5);
        chk("idle_busy0", 32'(w_busy0), 32'd0);
        chk("cnt_after_first", 32'(w_cnt0), 32'd1);

        // Sweep addr 0..7, D = 1,0,1,0...
        for (int i = 0; i < 8; i++) begin
            send_frame(3'(i), (i % 2) == 0, 1'b1, 7);
        end
        chk("cnt_after_sweep0", 32'(w_cnt0), 32'd9);
        chk("cnt_after_sweep1", 32'(w_cnt1), 32'd1);

        // Framing error, then a good frame
        send_frame(3'b011, 1'b1, 1'b0, 4);
        chk("err_busy0", 32'(w_busy0), 32'd0);
        chk("err_cnt0", 32'(w_cnt0), 32'd9);
        send_frame(3'b110, 1'b0, 1'b1, 7);
        chk("post_err_sel0", 32'(w_sel0), 32'd6);

        // Start bit on the clock right after the stop tick lands in DRIVE
        expect_frame(3'b010, 1'b1, 1'b1);
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        @(posedge r_clk); #1;
        r_ser_in = 1'b1; r_bit_tick = 1'b1;
        @(posedge r_clk); #1;
        r_ser_in = 1'b0;
        @(posedge r_clk); #1;
        r_bit_tick = 1'b0; r_ser_in = 1'b1;
        repeat (8) @(posedge r_clk);
        #1;
        chk("overlap_busy0", 32'(w_busy0), 32'd0);
        chk("overlap_busy1", 32'(w_busy1), 32'd0);

        // Line idle high with bit_tick held for 20 clocks
        r_ser_in = 1'b1; r_bit_tick = 1'b1;
        repeat (10) @(posedge r_clk);
        #1;
        chk("idle_mid_busy0", 32'(w_busy0), 32'd0);
        repeat (10) @(posedge r_clk);
        #1;
        r_bit_tick = 1'b0;
        chk("idle_end_busy0", 32'(w_busy0), 32'd0);

        // Reset mid-DRIVE with en high, then mid-ADDR
        send_frame(3'b100, 1'b1, 1'b1, 1);
        chk("pre_rst_en0", 32'(w_en0), 32'd1);
        do_reset();
        tick(1'b0); tick(1'b1);
        chk("mid_addr_busy0", 32'(w_busy0), 32'd1);
        do_reset();
        send_frame(3'b111, 1'b0, 1'b1, 8);
        chk("post_rst_sel0", 32'(w_sel0), 32'd7);
        chk("post_rst_cnt0", 32'(w_cnt0), 32'd1);

        repeat (5) @(posedge r_clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
